// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared encodings for the multi-cycle MIPS main controller.
//   state_t     controller state codes (12 used, remaining 4-bit codes unused)
//   OP_* / FN_* instruction-register Op and Funct field values
//   ALUOP_*     operation codes driven to the ALU
//   is_rtype    helper, true when Op selects the R-type (Funct-decoded) group
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEM_ADDR = 4'd3,
        S_MEM_RD   = 4'd4,
        S_MEM_WB   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_EXEC_R   = 4'd7,
        S_EXEC_I   = 4'd8,
        S_ALU_WB   = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11
    } state_t;

    localparam int STATE_BITS = $bits(state_t);

    // Op field
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // Funct field (R-type)
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    // ALU operation codes; NOP must stay zero so IDLE/reset drives all-zero outputs
    localparam logic [4:0] ALUOP_NOP  = 5'd0;
    localparam logic [4:0] ALUOP_ADD  = 5'd1;
    localparam logic [4:0] ALUOP_ADDU = 5'd2;
    localparam logic [4:0] ALUOP_SUB  = 5'd3;
    localparam logic [4:0] ALUOP_SUBU = 5'd4;
    localparam logic [4:0] ALUOP_AND  = 5'd5;
    localparam logic [4:0] ALUOP_OR   = 5'd6;
    localparam logic [4:0] ALUOP_NOR  = 5'd7;
    localparam logic [4:0] ALUOP_XOR  = 5'd8;
    localparam logic [4:0] ALUOP_SLT  = 5'd9;
    localparam logic [4:0] ALUOP_SLTU = 5'd10;
    localparam logic [4:0] ALUOP_SLL  = 5'd11;
    localparam logic [4:0] ALUOP_SRL  = 5'd12;
    localparam logic [4:0] ALUOP_SRA  = 5'd13;

    function automatic logic is_rtype(input logic [5:0] op);
        return op == OP_RTYPE;
    endfunction

endpackage

// File: rtl/mc_ctrl_if.sv
// mc_ctrl_if: controller <-> datapath bundle.
//   master : controller side (drives enables/selects/ALUOp/Illegal,
//            receives Op, Funct, Zero, mem_ready)
//   slave  : datapath/memory side (mirror image)
interface mc_ctrl_if;
    logic [5:0] Op;
    logic [5:0] Funct;
    logic       Zero;
    logic       mem_ready;

    logic       PCWrite;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegWrite;
    logic       RegDst;
    logic       MemtoReg;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] PCSource;
    logic [4:0] ALUOp;
    logic       Illegal;

    modport master (
        input  Op, Funct, Zero, mem_ready,
        output PCWrite, IorD, MemRead, MemWrite, IRWrite, RegWrite, RegDst,
               MemtoReg, ALUSrcA, ALUSrcB, PCSource, ALUOp, Illegal
    );

    modport slave (
        output Op, Funct, Zero, mem_ready,
        input  PCWrite, IorD, MemRead, MemWrite, IRWrite, RegWrite, RegDst,
               MemtoReg, ALUSrcA, ALUSrcB, PCSource, ALUOp, Illegal
    );
endinterface

// File: rtl/mc_ctrl_alu_dec.sv
// mc_alu_dec: combinational Op/Funct decoder.
//   op_i, funct_i : instruction register fields
//   alu_op_o      : ALU operation for the EXEC states
//   illegal_o     : Op (or Funct for R-type) is not a supported instruction
import mc_ctrl_pkg::*;

module mc_alu_dec (
    input  logic [5:0] op_i,
    input  logic [5:0] funct_i,
    output logic [4:0] alu_op_o,
    output logic       illegal_o
);

    always_comb begin
        alu_op_o  = ALUOP_NOP;
        illegal_o = 1'b0;
        case (op_i)
            OP_RTYPE: begin
                case (funct_i)
                    FN_ADDU: alu_op_o = ALUOP_ADDU;
                    FN_ADD:  alu_op_o = ALUOP_ADD;
                    FN_SUBU: alu_op_o = ALUOP_SUBU;
                    FN_SUB:  alu_op_o = ALUOP_SUB;
                    FN_AND:  alu_op_o = ALUOP_AND;
                    FN_OR:   alu_op_o = ALUOP_OR;
                    FN_NOR:  alu_op_o = ALUOP_NOR;
                    FN_XOR:  alu_op_o = ALUOP_XOR;
                    FN_SLT:  alu_op_o = ALUOP_SLT;
                    FN_SLTU: alu_op_o = ALUOP_SLTU;
                    FN_SLL:  alu_op_o = ALUOP_SLL;
                    FN_SRL:  alu_op_o = ALUOP_SRL;
                    FN_SRA:  alu_op_o = ALUOP_SRA;
                    default: illegal_o = 1'b1;
                endcase
            end
            // immediate zero-extension for the logical ops is a datapath concern
            OP_ADDI:        alu_op_o = ALUOP_ADD;
            OP_ADDIU:       alu_op_o = ALUOP_ADDU;
            OP_ANDI:        alu_op_o = ALUOP_AND;
            OP_ORI:         alu_op_o = ALUOP_OR;
            OP_XORI:        alu_op_o = ALUOP_XOR;
            OP_SLTI:        alu_op_o = ALUOP_SLT;
            OP_SLTIU:       alu_op_o = ALUOP_SLTU;
            OP_LW, OP_SW:   alu_op_o = ALUOP_ADDU;
            OP_BEQ, OP_BNE: alu_op_o = ALUOP_SUBU;
            OP_J:           alu_op_o = ALUOP_NOP;
            default:        illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle MIPS main controller (Moore FSM).
//   clk, rstn   : clock (rising edge), asynchronous active-low reset
//   bus         : mc_ctrl_if.master -- Op/Funct/Zero/mem_ready in,
//                 datapath enables, mux selects, ALUOp, Illegal out
//   cyc_cnt     : non-IDLE cycle count     (only with MC_CTRL_PERF_CNT_EN)
//   instr_cnt   : completed instructions   (only with MC_CTRL_PERF_CNT_EN)
// Optional feature macro: MC_CTRL_PERF_CNT_EN (performance counters, PERF_W wide).
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | after reset, all outputs low
// FETCH    | read instruction at PC, PC+4 -> PC; waits for mem_ready
// DECODE   | branch target -> ALUOut, dispatch on Op, flag Illegal
// MEM_ADDR | base + offset for lw/sw
// MEM_RD   | data read at ALUOut; waits for mem_ready
// MEM_WB   | MDR -> rt
// MEM_WR   | data write at ALUOut; waits for mem_ready
// EXEC_R   | A op B (Funct-selected)
// EXEC_I   | A op imm (Op-selected)
// ALU_WB   | ALUOut -> rd (R-type) or rt (I-type)
// BRANCH   | compare A,B; load PC from ALUOut if taken
// JUMP     | load PC with jump target
import mc_ctrl_pkg::*;

module mc_ctrl #(
    parameter int STATE_W = 4
`ifdef MC_CTRL_PERF_CNT_EN
   ,parameter int PERF_W  = 32
`endif
) (
    input  logic             clk,
    input  logic             rstn,
    mc_ctrl_if.master        bus
`ifdef MC_CTRL_PERF_CNT_EN
   ,output logic [PERF_W-1:0] cyc_cnt,
    output logic [PERF_W-1:0] instr_cnt
`endif
);

    logic [STATE_W-1:0] state_q;
    state_t             state_cur;
    state_t             state_d;

    logic [4:0] dec_alu_op;
    logic       dec_illegal;

    mc_alu_dec u_alu_dec (
        .op_i      (bus.Op),
        .funct_i   (bus.Funct),
        .alu_op_o  (dec_alu_op),
        .illegal_o (dec_illegal)
    );

    // codes outside the enumeration fall to the default arm and recover via FETCH
    assign state_cur = state_t'(state_q[STATE_BITS-1:0]);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= STATE_W'(S_IDLE);
        else       state_q <= STATE_W'(state_d);
    end

    always_comb begin
        state_d      = state_cur;
        bus.PCWrite  = 1'b0;
        bus.IorD     = 1'b0;
        bus.MemRead  = 1'b0;
        bus.MemWrite = 1'b0;
        bus.IRWrite  = 1'b0;
        bus.RegWrite = 1'b0;
        bus.RegDst   = 1'b0;
        bus.MemtoReg = 1'b0;
        bus.ALUSrcA  = 1'b0;
        bus.ALUSrcB  = 2'b00;
        bus.PCSource = 2'b00;
        bus.ALUOp    = ALUOP_NOP;
        bus.Illegal  = 1'b0;

        case (state_cur)
            S_IDLE: state_d = S_FETCH;

            S_FETCH: begin
                bus.MemRead = 1'b1;
                bus.ALUSrcB = 2'b01;
                bus.ALUOp   = ALUOP_ADDU;
                // PC and IR only load once memory has delivered the word
                bus.IRWrite = bus.mem_ready;
                bus.PCWrite = bus.mem_ready;
                if (bus.mem_ready) state_d = S_DECODE;
            end

            S_DECODE: begin
                bus.ALUSrcB = 2'b11;
                bus.ALUOp   = ALUOP_ADDU;
                if (dec_illegal) begin
                    // treated as a NOP: PC has already advanced in FETCH
                    bus.Illegal = 1'b1;
                    state_d     = S_FETCH;
                end else begin
                    case (bus.Op)
                        OP_RTYPE:       state_d = S_EXEC_R;
                        OP_LW, OP_SW:   state_d = S_MEM_ADDR;
                        OP_BEQ, OP_BNE: state_d = S_BRANCH;
                        OP_J:           state_d = S_JUMP;
                        default:        state_d = S_EXEC_I;
                    endcase
                end
            end

            S_EXEC_R: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'b00;
                bus.ALUOp   = dec_alu_op;
                state_d     = S_ALU_WB;
            end

            S_EXEC_I: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'b10;
                bus.ALUOp   = dec_alu_op;
                state_d     = S_ALU_WB;
            end

            S_ALU_WB: begin
                bus.RegWrite = 1'b1;
                bus.RegDst   = is_rtype(bus.Op);
                state_d      = S_FETCH;
            end

            S_MEM_ADDR: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'b10;
                bus.ALUOp   = ALUOP_ADDU;
                state_d     = (bus.Op == OP_LW) ? S_MEM_RD : S_MEM_WR;
            end

            S_MEM_RD: begin
                bus.MemRead = 1'b1;
                bus.IorD    = 1'b1;
                if (bus.mem_ready) state_d = S_MEM_WB;
            end

            S_MEM_WB: begin
                bus.RegWrite = 1'b1;
                bus.MemtoReg = 1'b1;
                state_d      = S_FETCH;
            end

            S_MEM_WR: begin
                bus.MemWrite = 1'b1;
                bus.IorD     = 1'b1;
                if (bus.mem_ready) state_d = S_FETCH;
            end

            S_BRANCH: begin
                bus.ALUSrcA  = 1'b1;
                bus.ALUSrcB  = 2'b00;
                bus.ALUOp    = ALUOP_SUBU;
                bus.PCSource = 2'b01;
                bus.PCWrite  = (bus.Op == OP_BEQ) ? bus.Zero : ~bus.Zero;
                state_d      = S_FETCH;
            end

            S_JUMP: begin
                bus.PCSource = 2'b10;
                bus.PCWrite  = 1'b1;
                state_d      = S_FETCH;
            end

            default: state_d = S_FETCH;
        endcase
    end

`ifdef MC_CTRL_PERF_CNT_EN
    logic [PERF_W-1:0] cyc_cnt_q;
    logic [PERF_W-1:0] instr_cnt_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cyc_cnt_q   <= '0;
            instr_cnt_q <= '0;
        end else begin
            if (state_cur != S_IDLE)
                cyc_cnt_q <= cyc_cnt_q + PERF_W'(1);
            // the IDLE->FETCH start-up entry is not a completed instruction
            if (state_d == S_FETCH && state_cur != S_FETCH && state_cur != S_IDLE)
                instr_cnt_q <= instr_cnt_q + PERF_W'(1);
        end
    end

    assign cyc_cnt   = cyc_cnt_q;
    assign instr_cnt = instr_cnt_q;
`endif

endmodule
